// File: rtl/crop_video_pkg.sv
// Shared definitions for the crop_video streaming crop engine: default widths,
// FSM state type and the buffered pixel beat layout.
package crop_video_pkg;

  localparam int DEF_DATA_W  = 24;
  localparam int DEF_COORD_W = 12;

  typedef enum logic {
    WAIT_SOF,
    IN_FRAME
  } crop_state_t;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic                  user;
    logic                  last;
  } pixel_beat_t;

endpackage

// File: rtl/crop_video_axis_skid.sv
// Two-entry skid buffer: registered output stage plus one overflow slot, so the
// upstream ready only depends on registered state.
module crop_video_axis_skid
  import crop_video_pkg::*;
#(
  parameter type beat_t = pixel_beat_t
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  in_valid,
  input  beat_t in_beat,
  output logic  in_ready,
  output logic  out_valid,
  output beat_t out_beat,
  input  logic  out_ready
);

  beat_t skid_beat;
  logic  skid_valid;

  // Space remains while the overflow slot is empty; held low during reset.
  assign in_ready = !skid_valid && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_beat   <= '0;
      skid_valid <= 1'b0;
      skid_beat  <= '0;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_beat   <= skid_beat;
        out_valid  <= 1'b1;
        skid_valid <= in_valid;
        if (in_valid) skid_beat <= in_beat;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_beat <= in_beat;
      end
    end else if (in_valid) begin
      skid_beat  <= in_beat;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/crop_video_axis_core.sv
// Streaming AXI4-Stream video crop: forwards only pixels inside a window latched
// at each start-of-frame, regenerating SOF/EOL markers for the cropped frame.
module crop_video_axis_core
  import crop_video_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int COORD_W = DEF_COORD_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [DATA_W-1:0]  s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic               s_axis_tuser,
  input  logic               s_axis_tlast,
  output logic [DATA_W-1:0]  m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tuser,
  output logic               m_axis_tlast,
  input  logic [COORD_W-1:0] cfg_x_start,
  input  logic [COORD_W-1:0] cfg_y_start,
  input  logic [COORD_W-1:0] cfg_width,
  input  logic [COORD_W-1:0] cfg_height,
  output logic               frame_done,
  output logic               err_short_line,
  output logic               err_early_sof,
  input  logic               err_clear
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              user;
    logic              last;
  } beat_t;

  localparam logic [COORD_W:0] ONE = 1;

  crop_state_t        state, state_next;
  logic [COORD_W-1:0] x_q, y_q, x0_q, y0_q, w_q, h_q;
  logic [COORD_W-1:0] ex, ey, ex0, ey0, ew, eh;
  logic [COORD_W-1:0] x_next, y_next;
  logic [COORD_W:0]   x_end, y_end, x_last, y_last;
  logic               accept, sof, active, zero, eval;
  logic               in_x, in_y, right_edge, short_line, done, keep;
  beat_t              in_beat, out_beat;

  assign accept = s_axis_tvalid && s_axis_tready;
  assign sof    = s_axis_tuser;

  // A SOF beat is evaluated with live cfg and origin coordinates, so the
  // restart (from either state) needs no extra cycle.
  always_comb begin
    ex  = sof ? '0 : x_q;
    ey  = sof ? '0 : y_q;
    ex0 = sof ? cfg_x_start : x0_q;
    ey0 = sof ? cfg_y_start : y0_q;
    ew  = sof ? cfg_width   : w_q;
    eh  = sof ? cfg_height  : h_q;

    x_end  = {1'b0, ex0} + {1'b0, ew};
    y_end  = {1'b0, ey0} + {1'b0, eh};
    x_last = x_end - ONE;
    y_last = y_end - ONE;

    in_x       = (ex >= ex0) && ({1'b0, ex} < x_end);
    in_y       = (ey >= ey0) && ({1'b0, ey} < y_end);
    right_edge = ({1'b0, ex} == x_last);

    active     = sof || (state == IN_FRAME);
    zero       = (ew == '0) || (eh == '0);
    eval       = accept && active && !zero;
    keep       = eval && in_x && in_y;
    short_line = eval && s_axis_tlast && in_y && ({1'b0, ex} < x_last);
    done       = eval && ({1'b0, ey} == y_last) && (right_edge || short_line);

    in_beat.data = s_axis_tdata;
    in_beat.user = (ex == ex0) && (ey == ey0);
    in_beat.last = right_edge || s_axis_tlast;

    state_next = state;
    if (accept) begin
      if (sof) begin
        state_next = (zero || done) ? WAIT_SOF : IN_FRAME;
      end else if ((state == IN_FRAME) && done) begin
        state_next = WAIT_SOF;
      end
    end

    if (s_axis_tlast) begin
      x_next = '0;
      y_next = (ey == '1) ? ey : ey + 1'b1;
    end else begin
      x_next = ey == ey ? ((ex == '1) ? ex : ex + 1'b1) : ex;
      y_next = ey;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= WAIT_SOF;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x_q            <= '0;
      y_q            <= '0;
      x0_q           <= '0;
      y0_q           <= '0;
      w_q            <= '0;
      h_q            <= '0;
      frame_done     <= 1'b0;
      err_short_line <= 1'b0;
      err_early_sof  <= 1'b0;
    end else begin
      frame_done <= done;
      if (accept) begin
        x_q <= x_next;
        y_q <= y_next;
        if (sof) begin
          x0_q <= cfg_x_start;
          y0_q <= cfg_y_start;
          w_q  <= cfg_width;
          h_q  <= cfg_height;
        end
      end
      if (short_line) begin
        err_short_line <= 1'b1;
      end else if (err_clear) begin
        err_short_line <= 1'b0;
      end
      if (accept && sof && (state == IN_FRAME)) begin
        err_early_sof <= 1'b1;
      end else if (err_clear) begin
        err_early_sof <= 1'b0;
      end
    end
  end

  crop_video_axis_skid #(
    .beat_t(beat_t)
  ) u_skid (
    .clock    (clock),
    .reset    (reset),
    .in_valid (keep),
    .in_beat  (in_beat),
    .in_ready (s_axis_tready),
    .out_valid(m_axis_tvalid),
    .out_beat (out_beat),
    .out_ready(m_axis_tready)
  );

  assign m_axis_tdata = out_beat.data;
  assign m_axis_tuser = out_beat.user;
  assign m_axis_tlast = out_beat.last;

endmodule

// File: tb/tb_crop_video_axis_core.sv
// Scoreboard bench for crop_video_axis_core: a frame-level crop model fills the
// expected queue, a negedge monitor pops and compares every output handshake.
module tb_crop_video_axis_core;

  localparam int DW = 24;
  localparam int CW = 12;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tuser = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tuser;
  logic          m_axis_tlast;
  logic [CW-1:0] cfg_x_start = '0, cfg_y_start = '0, cfg_width = '0, cfg_height = '0;
  logic          frame_done, err_short_line, err_early_sof;
  logic          err_clear = 1'b0;

  crop_video_axis_core #(.DATA_W(DW), .COORD_W(CW)) dut (
    .clock(clock), .reset(reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .cfg_x_start(cfg_x_start), .cfg_y_start(cfg_y_start),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .frame_done(frame_done), .err_short_line(err_short_line),
    .err_early_sof(err_early_sof), .err_clear(err_clear)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          user;
    logic          last;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;
  int   exp_done = 0;
  bit   exp_short = 0;
  bit   exp_early = 0;
  bit   pending = 0;
  int   ready_mode = 0;  // 0: always ready, 1: random, 2: held low
  bit   gap_en = 0;
  int   row_len[64];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endfunction

  function automatic logic [DW-1:0] pix(input int fid, input int x, input int y);
    if (fid == 0) return DW'(y * 16 + x);
    return DW'((fid << 16) | (y << 8) | x);
  endfunction

  // Downstream ready changes just after the clock edge.
  always @(posedge clock) begin
    #1;
    case (ready_mode)
      0: m_axis_tready = 1'b1;
      1: m_axis_tready = 1'($urandom_range(0, 1));
      default: m_axis_tready = 1'b0;
    endcase
  end

  bit   stalled = 0;
  exp_t held;
  always @(negedge clock) begin
    if (reset) begin
      stalled = 0;
    end else begin
      if (stalled)
        check("hold", {m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast}, {1'b1, held});
      if (m_axis_tvalid && m_axis_tready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", {m_axis_tdata, m_axis_tuser, m_axis_tlast}, 64'hDEAD);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("beat", {m_axis_tdata, m_axis_tuser, m_axis_tlast}, e);
        end
        stalled = 0;
      end else if (m_axis_tvalid) begin
        stalled = 1;
        held = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
      end else begin
        stalled = 0;
      end
      if (frame_done) done_cnt++;
    end
  end

  // Frame-level reference: rows y0..y0+h-1 present in the frame, each clipped
  // to the shorter of the window edge and the row's actual length.
  task automatic model_frame(input int nrows, input int fid, input int x0, y0, w, h);
    if (w == 0 || h == 0) return;
    for (int r = y0; r < y0 + h && r < nrows; r++) begin
      int end_x;
      end_x = (x0 + w < row_len[r]) ? x0 + w : row_len[r];
      if (row_len[r] < x0 + w) exp_short = 1;
      for (int x = x0; x < end_x; x++)
        sb.push_back({pix(fid, x, r), 1'(x == x0 && r == y0), 1'(x == end_x - 1)});
    end
    if (y0 + h <= nrows) exp_done++;
  endtask

  task automatic drive_beat(input logic [DW-1:0] d, input logic u, input logic l);
    bit acc;
    int n;
    if (gap_en) while ($urandom_range(0, 2) == 0) begin @(posedge clock); #1; end
    s_axis_tdata = d; s_axis_tuser = u; s_axis_tlast = l; s_axis_tvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      acc = s_axis_tready;
      n++;
      @(posedge clock); #1;
    end while (!acc && n < 2000);
    if (!acc) check("input_accept_timeout", 0, 1);
    s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic send_frame(input int nrows, input int fid, input int x0, y0, w, h, input bit scramble);
    if (pending) exp_early = 1;
    pending = (w != 0 && h != 0 && y0 + h > nrows);
    model_frame(nrows, fid, x0, y0, w, h);
    cfg_x_start = CW'(x0); cfg_y_start = CW'(y0); cfg_width = CW'(w); cfg_height = CW'(h);
    for (int r = 0; r < nrows; r++)
      for (int x = 0; x < row_len[r]; x++) begin
        drive_beat(pix(fid, x, r), 1'(r == 0 && x == 0), 1'(x == row_len[r] - 1));
        if (scramble && r == 0 && x == 0) begin
          cfg_x_start = CW'($urandom); cfg_y_start = CW'($urandom);
          cfg_width = CW'($urandom); cfg_height = CW'($urandom);
        end
      end
  endtask

  task automatic drain_and_check(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || m_axis_tvalid) && n < 3000) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      check({tag, "_drain_timeout"}, 64'(sb.size()), 0);
      sb.delete();
    end
    repeat (3) @(negedge clock);
    check({tag, "_frame_done_count"}, 64'(done_cnt), 64'(exp_done));
    check({tag, "_err_short_line"}, 64'(err_short_line), 64'(exp_short));
    check({tag, "_err_early_sof"}, 64'(err_early_sof), 64'(exp_early));
    @(posedge clock); #1 err_clear = 1'b1;
    @(posedge clock); #1 err_clear = 1'b0;
    exp_short = 0; exp_early = 0;
    @(negedge clock);
    check({tag, "_err_cleared"}, {err_short_line, err_early_sof}, 2'b00);
    @(posedge clock); #1;
  endtask

  task automatic set_rows(input int n, input int len);
    for (int i = 0; i < n; i++) row_len[i] = len;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_s_tready", s_axis_tready, 0);
    check("reset_m_axis", {m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast}, 0);
    check("reset_status", {frame_done, err_short_line, err_early_sof}, 0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("post_reset_s_tready", s_axis_tready, 1);
    @(posedge clock); #1;

    set_rows(4, 8);
    send_frame(4, 0, 2, 1, 3, 2, 0);
    drain_and_check("basic");

    ready_mode = 1;
    send_frame(4, 0, 2, 1, 3, 2, 0);
    drain_and_check("backpressure");
    ready_mode = 0;

    set_rows(4, 8); row_len[1] = 6;
    send_frame(4, 0, 2, 1, 5, 2, 0);
    drain_and_check("short_line");

    set_rows(4, 8);
    send_frame(2, 0, 2, 1, 3, 2, 0);
    send_frame(4, 0, 2, 1, 3, 2, 0);
    drain_and_check("early_sof");

    send_frame(4, 0, 0, 0, 0, 2, 0);
    send_frame(4, 0, 0, 0, 1, 1, 0);
    drain_and_check("zero_size");

    // Reset mid-frame with 0x14 stuck in the output stage.
    cfg_x_start = 2; cfg_y_start = 1; cfg_width = 3; cfg_height = 2;
    sb.push_back({pix(0, 2, 1), 1'b1, 1'b0});
    sb.push_back({pix(0, 3, 1), 1'b0, 1'b0});
    for (int x = 0; x < 8; x++) drive_beat(pix(0, x, 0), 1'(x == 0), 1'(x == 7));
    for (int x = 0; x < 4; x++) drive_beat(pix(0, x, 1), 1'b0, 1'b0);
    repeat (3) @(negedge clock);
    check("pre_reset_drained", 64'(sb.size()), 0);
    @(posedge clock); #1 ready_mode = 2;
    drive_beat(pix(0, 4, 1), 1'b0, 1'b0);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    ready_mode = 0;
    sb.delete();
    pending = 0;
    @(negedge clock);
    check("midreset_m_axis", {m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast}, 0);
    check("midreset_status", {frame_done, err_short_line, err_early_sof}, 0);
    @(posedge clock); #1;
    send_frame(4, 0, 2, 1, 3, 2, 0);
    drain_and_check("after_reset");

    for (int f = 1; f <= 10; f++) begin
      int nr;
      nr = $urandom_range(1, 6);
      for (int r = 0; r < nr; r++) row_len[r] = $urandom_range(1, 12);
      ready_mode = $urandom_range(0, 1);
      gap_en = 1'($urandom_range(0, 1));
      send_frame(nr, f, $urandom_range(0, 8), $urandom_range(0, 4),
                 $urandom_range(0, 8), $urandom_range(0, 4), 1);
      drain_and_check("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/crop_video_axis_core.md
# crop_video_axis_core

Streaming crop engine that sits directly downstream of the crop_video AXI4-Stream video source. It accepts one raster frame per start-of-frame marker and forwards only the pixels inside a runtime-programmed rectangular window. The output is a new AXI4-Stream video frame, with start-of-frame and end-of-line markers regenerated for the cropped geometry. It reports frame completion and geometry errors to the control side.

## Interface
Parameters:
- DATA_W, 24, pixel width (tdata bits)
- COORD_W, 12, coordinate and size width (frames up to 4095x4095)

Ports:
- clock  in  1  single clock for all logic
- reset  in  1  synchronous, active-high
- s_axis_tdata  in  DATA_W  input pixel
- s_axis_tvalid  in  1  input beat valid
- s_axis_tready  out  1  input beat accepted when high with tvalid
- s_axis_tuser  in  1  start of frame, on the first pixel of the frame
- s_axis_tlast  in  1  end of line, on the last pixel of each row
- m_axis_tdata  out  DATA_W  cropped pixel
- m_axis_tvalid  out  1  output beat valid
- m_axis_tready  in  1  downstream ready
- m_axis_tuser  out  1  start of cropped frame
- m_axis_tlast  out  1  end of cropped line
- cfg_x_start, cfg_y_start  in  COORD_W  window origin
- cfg_width, cfg_height  in  COORD_W  window size in pixels and lines
- frame_done  out  1  one-cycle pulse when the last window pixel is accepted
- err_short_line  out  1  sticky: an input line ended before the window's right edge
- err_early_sof  out  1  sticky: a SOF arrived before the window completed
- err_clear  in  1  clears both sticky errors. Set has priority over clear in the same cycle.

## Operation
- FSM with two states: WAIT_SOF and IN_FRAME.
- **WAIT_SOF:**
  - Accepted beats with tuser=0 are discarded.
  - An accepted beat with tuser=1 latches cfg_*, sets x=0 and y=0, is evaluated as pixel (0,0), and moves the FSM to IN_FRAME.
- **Zero-size window:** if the latched width or height is 0, the frame produces no output and no frame_done. The FSM stays in WAIT_SOF.
- **IN_FRAME, per accepted beat:**
  - The beat is kept when x_start ≤ x < x_start+width and y_start ≤ y < y_start+height.
  - Window ends are computed at COORD_W+1 bits, so they never wrap.
- **Counter update after each accepted beat:**
  - tlast=1: x=0, y=y+1.
  - Otherwise: x=x+1, saturating at all-ones.
- **Output markers on kept beats:**
  - m_tuser=1 on pixel (x_start, y_start).
  - m_tlast=1 when x = x_start+width-1, or when s_tlast=1.
- **Short line:** the case s_tlast=1 with x < x_start+width-1 on a row inside the window.
  - Sets err_short_line.
  - If the beat is kept, it carries tlast.
  - If the line ends before x_start, nothing is emitted for that row and the row still counts toward the height.
- **Window completion:** on acceptance of the beat that ends row y_start+height-1 of the window:
  - "Ends" means either x reaches the window's right edge, or a short line ends that row.
  - frame_done pulses and the FSM returns to WAIT_SOF; remaining input beats are discarded.
- **Early SOF:** a tuser=1 beat in IN_FRAME sets err_early_sof and restarts the frame exactly as from WAIT_SOF.
  - cfg is re-latched, x=0, y=0.
  - The beat is evaluated as pixel (0,0).
- **Configuration changes:** cfg_* changes take effect only at the next SOF.

## Timing
- **Latency:** one cycle from input acceptance to m_axis_tvalid, when the output is not stalled.
- **Backpressure:** s_axis_tready = skid buffer not full, in every state, so discarded beats also wait for space.
  - Full throughput (one beat per clock) is sustained while m_axis_tready=1.
- **Output hold:** once m_axis_tvalid rises, m_axis_tdata, tuser and tlast hold until m_axis_tready.
- **Reset values:** all m_axis_* outputs 0; s_axis_tready 0 during reset and 1 on the first cycle after it; frame_done 0; both errors 0; FSM in WAIT_SOF.
- **Reset mid-frame:** buffered beats are flushed and not emitted.
- **frame_done timing:** asserted in the cycle after the completing input handshake. It does not wait for downstream drain.

## Structure
- Shared package crop_video_pkg holds:
  - DATA_W and COORD_W defaults
  - the state enum type (WAIT_SOF, IN_FRAME)
  - a pixel beat struct {data, user, last}
- Sub-module crop_video_axis_skid is a 2-entry skid buffer.
  - It provides the registered output and the s_axis_tready generation.
- Coordinate counters, window compare and FSM live in the top.

## Test plan
Pixel value = y*16+x on an 8x4 input frame unless stated otherwise.
- **Basic crop:** window (2,1,3,2), m_tready=1 → output 0x12, 0x13, 0x14(tlast), 0x22, 0x23, 0x24(tlast); tuser only on 0x12; frame_done once; no errors.
- **Random backpressure:** same frame, m_tready 50% random → identical beat sequence with no loss or duplication; data stable while stalled.
- **Short line:** window (2,1,5,2), row 1 ends at x=5 → row 1 outputs 0x12–0x15, with 0x15 tlast; err_short_line=1; row 2 outputs 0x22–0x26(tlast).
- **Early SOF:** new SOF after row 1 → err_early_sof=1; the second frame's crop is output in full; a single frame_done, for the second frame.
- **Zero size:** window (0,0,0,2) → no output beats, no frame_done; next frame with window (0,0,1,1) → single beat 0x00, with tuser=1 and tlast=1.
- **Reset mid-frame:** reset asserted for 1 cycle after 0x13 is emitted → all outputs 0; a following full frame crops correctly from its SOF.
